// File: rtl/pcie3_cfg_msg_received_collector_if.sv
// Bundles the cfg_msg_received sideband and the record-out valid/ready bus.
// Optional m_msg_timestamp exists when PCIE3_CFG_MSG_RECEIVED_TIMESTAMP_EN is defined.
interface pcie3_cfg_msg_received_collector_if #(
  parameter int unsigned C_RECD_DATA_WIDTH = 8,
  parameter int unsigned C_RECD_TYPE_WIDTH = 5,
  parameter int unsigned C_MAX_BYTES       = 8
);
  localparam int unsigned LenW = $clog2(C_MAX_BYTES + 1);

  logic                         s_recd;
  logic [C_RECD_DATA_WIDTH-1:0] s_recd_data;
  logic [C_RECD_TYPE_WIDTH-1:0] s_recd_type;

  logic                         m_msg_valid;
  logic                         m_msg_ready;
  logic [C_RECD_TYPE_WIDTH-1:0] m_msg_type;
  logic [8*C_MAX_BYTES-1:0]     m_msg_data;
  logic [LenW-1:0]              m_msg_len;
  logic                         m_msg_trunc;
`ifdef PCIE3_CFG_MSG_RECEIVED_TIMESTAMP_EN
  logic [31:0]                  m_msg_timestamp;

  modport slave (
    input  s_recd, s_recd_data, s_recd_type, m_msg_ready,
    output m_msg_valid, m_msg_type, m_msg_data, m_msg_len, m_msg_trunc, m_msg_timestamp
  );
  modport master (
    output s_recd, s_recd_data, s_recd_type, m_msg_ready,
    input  m_msg_valid, m_msg_type, m_msg_data, m_msg_len, m_msg_trunc, m_msg_timestamp
  );
`else
  modport slave (
    input  s_recd, s_recd_data, s_recd_type, m_msg_ready,
    output m_msg_valid, m_msg_type, m_msg_data, m_msg_len, m_msg_trunc
  );
  modport master (
    output s_recd, s_recd_data, s_recd_type, m_msg_ready,
    input  m_msg_valid, m_msg_type, m_msg_data, m_msg_len, m_msg_trunc
  );
`endif
endinterface

// File: rtl/pcie3_cfg_msg_received_collector.sv
// Assembles cfg_msg_received bursts into records and queues them in a FWFT FIFO.
// Define PCIE3_CFG_MSG_RECEIVED_TIMESTAMP_EN to tag each record with a cycle timestamp.
module pcie3_cfg_msg_received_collector #(
  parameter int unsigned C_RECD_DATA_WIDTH = 8,
  parameter int unsigned C_RECD_TYPE_WIDTH = 5,
  parameter int unsigned C_MAX_BYTES       = 8,
  parameter int unsigned C_FIFO_DEPTH      = 4
) (
  input  logic                                     aclk,
  input  logic                                     areset,
  pcie3_cfg_msg_received_collector_if.slave        bus,
  output logic [15:0]                              drop_count
);
  localparam int unsigned LenW  = $clog2(C_MAX_BYTES + 1);
  localparam int unsigned DataW = 8 * C_MAX_BYTES;
  localparam int unsigned PtrW  = $clog2(C_FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;

  typedef enum logic [0:0] {StIdle, StCollect} state_e;

  state_e                       state_q, state_d;
  logic [C_RECD_TYPE_WIDTH-1:0] buf_type_q, buf_type_d;
  logic [DataW-1:0]             buf_data_q, buf_data_d;
  logic [LenW-1:0]              buf_len_q, buf_len_d;
  logic                         buf_trunc_q, buf_trunc_d;
  logic                         push;

  logic [C_RECD_TYPE_WIDTH-1:0] mem_type  [C_FIFO_DEPTH];
  logic [DataW-1:0]             mem_data  [C_FIFO_DEPTH];
  logic [LenW-1:0]              mem_len   [C_FIFO_DEPTH];
  logic                         mem_trunc [C_FIFO_DEPTH];
  logic [PtrW-1:0]              wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]              count_q, count_d;
  logic                         fifo_valid, pop, push_ok, drop;
  logic [15:0]                  drop_count_q;

`ifdef PCIE3_CFG_MSG_RECEIVED_TIMESTAMP_EN
  logic [31:0] ts_q;
  logic [31:0] buf_ts_q, buf_ts_d;
  logic [31:0] mem_ts [C_FIFO_DEPTH];

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ts_q     <= '0;
      buf_ts_q <= '0;
    end else begin
      ts_q     <= ts_q + 32'd1;
      buf_ts_q <= buf_ts_d;
    end
  end

  always_comb begin
    buf_ts_d = buf_ts_q;
    if (state_q == StIdle && bus.s_recd) buf_ts_d = ts_q;
  end

  always_ff @(posedge aclk) begin
    if (push_ok) mem_ts[wr_ptr_q] <= buf_ts_q;
  end

  assign bus.m_msg_timestamp = fifo_valid ? mem_ts[rd_ptr_q] : '0;
`endif

  // Assembly FSM
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= StIdle;
      buf_type_q  <= '0;
      buf_data_q  <= '0;
      buf_len_q   <= '0;
      buf_trunc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_type_q  <= buf_type_d;
      buf_data_q  <= buf_data_d;
      buf_len_q   <= buf_len_d;
      buf_trunc_q <= buf_trunc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    buf_type_d  = buf_type_q;
    buf_data_d  = buf_data_q;
    buf_len_d   = buf_len_q;
    buf_trunc_d = buf_trunc_q;
    push        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.s_recd) begin
          // Whole buffer cleared so a short message never exposes older bytes.
          buf_type_d       = bus.s_recd_type;
          buf_data_d       = '0;
          buf_data_d[7:0]  = bus.s_recd_data[7:0];
          buf_len_d        = LenW'(1);
          buf_trunc_d      = 1'b0;
          state_d          = StCollect;
        end
      end
      StCollect: begin
        if (bus.s_recd) begin
          if (buf_len_q < LenW'(C_MAX_BYTES)) begin
            buf_data_d[8*int'(buf_len_q) +: 8] = bus.s_recd_data[7:0];
            buf_len_d = buf_len_q + LenW'(1);
          end else begin
            buf_trunc_d = 1'b1;
          end
        end else begin
          push    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Record FIFO; a full FIFO still accepts a push when the head leaves this cycle.
  assign fifo_valid = (count_q != '0);
  assign pop        = fifo_valid & bus.m_msg_ready;
  assign push_ok    = push & ((count_q < CntW'(C_FIFO_DEPTH)) | pop);
  assign drop       = push & ~push_ok;

  always_comb begin
    count_d = count_q + CntW'(push_ok) - CntW'(pop);
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      drop_count_q <= '0;
    end else begin
      count_q <= count_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (drop && drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;
    end
  end

  always_ff @(posedge aclk) begin
    if (push_ok) begin
      mem_type[wr_ptr_q]  <= buf_type_q;
      mem_data[wr_ptr_q]  <= buf_data_q;
      mem_len[wr_ptr_q]   <= buf_len_q;
      mem_trunc[wr_ptr_q] <= buf_trunc_q;
    end
  end

  assign bus.m_msg_valid = fifo_valid;
  assign bus.m_msg_type  = fifo_valid ? mem_type[rd_ptr_q]  : '0;
  assign bus.m_msg_data  = fifo_valid ? mem_data[rd_ptr_q]  : '0;
  assign bus.m_msg_len   = fifo_valid ? mem_len[rd_ptr_q]   : '0;
  assign bus.m_msg_trunc = fifo_valid ? mem_trunc[rd_ptr_q] : 1'b0;
  assign drop_count      = drop_count_q;

endmodule

// File: tb/tb_pcie3_cfg_msg_received_collector.sv
// Directed bench for pcie3_cfg_msg_received_collector with a queue-based reference model.
module tb_pcie3_cfg_msg_received_collector;
  localparam int MaxBytes = 8;
  localparam int Depth    = 4;

  typedef struct packed {
    logic [4:0]  t;
    logic [63:0] d;
    logic [3:0]  len;
    logic        trunc;
    logic [31:0] ts;
  } rec_t;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic [15:0] drop_count;
  int          checks = 0;
  int          errors = 0;

  pcie3_cfg_msg_received_collector_if bus_if ();

  pcie3_cfg_msg_received_collector dut (
    .aclk       (clk),
    .areset     (areset),
    .bus        (bus_if),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: bytes per burst collected in a list, records in a bounded queue.
  rec_t        mq[$];
  logic [7:0]  cur_bytes[$];
  logic [4:0]  cur_type;
  logic [31:0] cur_ts;
  logic        in_burst;
  int          m_drops;
  logic [31:0] cyc;

  always @(posedge clk or posedge areset) begin
    if (areset) begin
      mq.delete();
      cur_bytes.delete();
      in_burst = 1'b0;
      m_drops  = 0;
      cyc      = '0;
    end else begin
      logic popped;
      popped = (mq.size() != 0) && bus_if.m_msg_ready;
      if (popped) void'(mq.pop_front());
      if (bus_if.s_recd) begin
        if (!in_burst) begin
          in_burst = 1'b1;
          cur_bytes.delete();
          cur_type = bus_if.s_recd_type;
          cur_ts   = cyc;
        end
        cur_bytes.push_back(bus_if.s_recd_data);
      end else if (in_burst) begin
        rec_t r;
        in_burst = 1'b0;
        r.t = cur_type;
        r.d = '0;
        r.len = (cur_bytes.size() > MaxBytes) ? 4'(MaxBytes) : 4'(cur_bytes.size());
        r.trunc = cur_bytes.size() > MaxBytes;
        r.ts = cur_ts;
        for (int i = 0; i < int'(r.len); i++) r.d[8*i +: 8] = cur_bytes[i];
        if (mq.size() < Depth) mq.push_back(r);
        else if (m_drops < 16'hFFFF) m_drops++;
      end
      cyc = cyc + 32'd1;
    end
  end

  // Compare process
  always @(negedge clk) begin
    if (!areset) begin
      check("valid", 64'(bus_if.m_msg_valid), 64'(mq.size() != 0));
      check("drop_count", 64'(drop_count), 64'(m_drops));
      if (mq.size() != 0) begin
        check("type", 64'(bus_if.m_msg_type), 64'(mq[0].t));
        check("data", bus_if.m_msg_data, mq[0].d);
        check("len", 64'(bus_if.m_msg_len), 64'(mq[0].len));
        check("trunc", 64'(bus_if.m_msg_trunc), 64'(mq[0].trunc));
`ifdef PCIE3_CFG_MSG_RECEIVED_TIMESTAMP_EN
        check("timestamp", 64'(bus_if.m_msg_timestamp), 64'(mq[0].ts));
`endif
      end else begin
        check("empty_fields", {bus_if.m_msg_data}, 64'h0);
        check("empty_meta", 64'({bus_if.m_msg_type, bus_if.m_msg_len, bus_if.m_msg_trunc}), 64'h0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic [4:0] t);
    bus_if.s_recd      = 1'b1;
    bus_if.s_recd_data = d;
    bus_if.s_recd_type = t;
    step();
  endtask

  task automatic commit();
    bus_if.s_recd      = 1'b0;
    bus_if.s_recd_data = '0;
    bus_if.s_recd_type = '0;
    step();
  endtask

  initial begin
    int popped;
    bus_if.s_recd      = 1'b0;
    bus_if.s_recd_data = '0;
    bus_if.s_recd_type = '0;
    bus_if.m_msg_ready = 1'b0;
    repeat (3) step();
    areset = 1'b0;
    @(negedge clk);
    check("reset_valid", 64'(bus_if.m_msg_valid), 64'h0);
    check("reset_drop", 64'(drop_count), 64'h0);
    step();

    // 3-beat burst
    bus_if.m_msg_ready = 1'b1;
    beat(8'h11, 5'h10); beat(8'h22, 5'h1F); beat(8'h33, 5'h00); commit();
    @(negedge clk);
    check("t1_valid", 64'(bus_if.m_msg_valid), 64'h1);
    check("t1_data", bus_if.m_msg_data, 64'h0000_0000_0033_2211);
    check("t1_len", 64'(bus_if.m_msg_len), 64'h3);
    step();

    // 10-beat burst truncated to 8
    for (int i = 1; i <= 10; i++) beat(8'(i), 5'h04);
    commit();
    @(negedge clk);
    check("t2_data", bus_if.m_msg_data, 64'h0807_0605_0403_0201);
    check("t2_trunc", 64'({bus_if.m_msg_len, bus_if.m_msg_trunc}), 64'({4'd8, 1'b1}));
    step();

    // Two 1-beat bursts with a 1-cycle gap
    bus_if.m_msg_ready = 1'b0;
    beat(8'hAA, 5'h02); commit(); beat(8'hBB, 5'h03); commit();
    @(negedge clk);
    check("t3_first", 64'({bus_if.m_msg_type, bus_if.m_msg_data[7:0]}), 64'({5'h02, 8'hAA}));
    bus_if.m_msg_ready = 1'b1;
    step();
    @(negedge clk);
    check("t3_second", 64'({bus_if.m_msg_type, bus_if.m_msg_data[7:0]}), 64'({5'h03, 8'hBB}));
    step();
    step();

    // Five messages into a 4-deep FIFO with no consumer
    bus_if.m_msg_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      beat(8'h40 + 8'(i), 5'(i + 8));
      commit();
    end
    @(negedge clk);
    check("t4_drop", 64'(drop_count), 64'h1);
    step();
    bus_if.m_msg_ready = 1'b1;
    repeat (5) step();
    @(negedge clk);
    check("t4_drained", 64'(bus_if.m_msg_valid), 64'h0);
    step();

    // Full FIFO, commit coincides with a pop
    bus_if.m_msg_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      beat(8'h60 + 8'(i), 5'h0A);
      commit();
    end
    beat(8'h99, 5'h09);
    bus_if.m_msg_ready = 1'b1;
    commit();
    bus_if.m_msg_ready = 1'b0;
    @(negedge clk);
    check("t5_drop", 64'(drop_count), 64'h1);
    step();
    bus_if.m_msg_ready = 1'b1;
    popped = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus_if.m_msg_valid) popped++;
      step();
    end
    check("t5_count", 64'(popped), 64'h4);

    // Reset during beat 2 of a 4-beat burst
    bus_if.m_msg_ready = 1'b0;
    beat(8'h01, 5'h04);
    bus_if.s_recd_data = 8'h02;
    #2 areset = 1'b1;
    step();
    bus_if.s_recd = 1'b0;
    step();
    areset = 1'b0;
    @(negedge clk);
    check("t6_valid", 64'(bus_if.m_msg_valid), 64'h0);
    check("t6_drop", 64'(drop_count), 64'h0);
    step();
    beat(8'h5C, 5'h07); commit();
    @(negedge clk);
    check("t6_len", 64'(bus_if.m_msg_len), 64'h1);
    check("t6_data", bus_if.m_msg_data, 64'h0000_0000_0000_005C);
    step();
    bus_if.m_msg_ready = 1'b1;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
